// File: rtl/id_stage_ctrl.sv
// Instruction-decode stage control: opcode decode, load-use hazard detection,
// and the ID/EX pipeline register with stall, bubble and flush handling.
module id_stage_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_inst,
    input  logic [DATA_W-1:0] in_pc,
    output logic              in_ready,
    output logic [2:0]        imm_type,
    input  logic              ex_ready,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_inst,
    output logic [DATA_W-1:0] out_pc,
    output logic [2:0]        out_imm_type,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [4:0]        out_rd,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_illegal,
    output logic [15:0]       bubble_cnt
);

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [6:0] w_opcode;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [4:0] w_rd;
    logic [2:0] w_imm_type;
    logic       w_use_rs1;
    logic       w_use_rs2;
    logic       w_wr_rd;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_illegal;
    logic       w_load_en;
    logic       w_hazard;

    logic              r_vld_p1;
    logic [DATA_W-1:0] r_inst_p1;
    logic [DATA_W-1:0] r_pc_p1;
    logic [2:0]        r_imm_type_p1;
    logic [4:0]        r_rs1_p1;
    logic [4:0]        r_rs2_p1;
    logic [4:0]        r_rd_p1;
    logic              r_reg_write_p1;
    logic              r_mem_read_p1;
    logic              r_mem_write_p1;
    logic              r_illegal_p1;
    logic [15:0]       r_bubble_cnt;

    assign w_opcode = in_inst[6:0];
    assign w_rd     = in_inst[11:7];
    assign w_rs1    = in_inst[19:15];
    assign w_rs2    = in_inst[24:20];

    always_comb begin
        w_imm_type  = IMM_NONE;
        w_use_rs1   = 1'b0;
        w_use_rs2   = 1'b0;
        w_wr_rd     = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_illegal   = 1'b0;
        case (w_opcode)
            OP_R: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_wr_rd   = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                w_imm_type = IMM_I;
                w_use_rs1  = 1'b1;
                w_wr_rd    = 1'b1;
                w_mem_read = (w_opcode == OP_LOAD);
            end
            OP_STORE: begin
                w_imm_type  = IMM_S;
                w_use_rs1   = 1'b1;
                w_use_rs2   = 1'b1;
                w_mem_write = 1'b1;
            end
            OP_BRANCH: begin
                w_imm_type = IMM_B;
                w_use_rs1  = 1'b1;
                w_use_rs2  = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                w_imm_type = IMM_U;
                w_wr_rd    = 1'b1;
            end
            OP_JAL: begin
                w_imm_type = IMM_J;
                w_wr_rd    = 1'b1;
            end
            OP_FENCE: ;
            default: w_illegal = 1'b1;
        endcase
    end

    // Load-use: the instruction in ID reads the register a load in EX is about to fill.
    assign w_load_en = ~r_vld_p1 | ex_ready;
    assign w_hazard  = in_valid & r_vld_p1 & r_mem_read_p1 & (r_rd_p1 != 5'd0) &
                       ((w_use_rs1 & (w_rs1 == r_rd_p1)) | (w_use_rs2 & (w_rs2 == r_rd_p1)));

    assign in_ready = w_load_en & ~w_hazard & ~flush & ~rst;
    assign imm_type = w_imm_type;

    // ID -> EX boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1       <= 1'b0;
            r_inst_p1      <= '0;
            r_pc_p1        <= '0;
            r_imm_type_p1  <= IMM_NONE;
            r_rs1_p1       <= '0;
            r_rs2_p1       <= '0;
            r_rd_p1        <= '0;
            r_reg_write_p1 <= 1'b0;
            r_mem_read_p1  <= 1'b0;
            r_mem_write_p1 <= 1'b0;
            r_illegal_p1   <= 1'b0;
            r_bubble_cnt   <= '0;
        end else if (flush) begin
            r_vld_p1 <= 1'b0;
        end else if (w_load_en) begin
            if (w_hazard) begin
                r_vld_p1     <= 1'b0;
                r_bubble_cnt <= sat_inc(r_bubble_cnt);
            end else if (in_valid) begin
                r_vld_p1       <= 1'b1;
                r_inst_p1      <= in_inst;
                r_pc_p1        <= in_pc;
                r_imm_type_p1  <= w_imm_type;
                r_rs1_p1       <= w_rs1;
                r_rs2_p1       <= w_rs2;
                r_rd_p1        <= w_rd;
                r_reg_write_p1 <= w_wr_rd & (w_rd != 5'd0);
                r_mem_read_p1  <= w_mem_read;
                r_mem_write_p1 <= w_mem_write;
                r_illegal_p1   <= w_illegal;
            end else begin
                r_vld_p1 <= 1'b0;
            end
        end
    end

    assign out_valid     = r_vld_p1;
    assign out_inst      = r_inst_p1;
    assign out_pc        = r_pc_p1;
    assign out_imm_type  = r_imm_type_p1;
    assign out_rs1       = r_rs1_p1;
    assign out_rs2       = r_rs2_p1;
    assign out_rd        = r_rd_p1;
    assign out_reg_write = r_reg_write_p1;
    assign out_mem_read  = r_mem_read_p1;
    assign out_mem_write = r_mem_write_p1;
    assign out_illegal   = r_illegal_p1;
    assign bubble_cnt    = r_bubble_cnt;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Directed bench for id_stage_ctrl: decode, load-use bubbles, stall, flush,
// counter saturation and reset override.
module tb_id_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        in_ready;
    logic [2:0]  imm_type;
    logic        ex_ready;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [2:0]  out_imm_type;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_illegal;
    logic [15:0] bubble_cnt;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] LUI_X5   = 32'h000052B7;
    localparam logic [31:0] LW_X6    = 32'h0000A303;
    localparam logic [31:0] ADD_X7   = 32'h002303B3;
    localparam logic [31:0] LW_X0    = 32'h0000A003;
    localparam logic [31:0] ADD_X0   = 32'h002003B3;
    localparam logic [31:0] SW_X2    = 32'h0020A223;
    localparam logic [31:0] BAD_OP   = 32'h00000FFF;

    id_stage_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc),
        .in_ready(in_ready), .imm_type(imm_type), .ex_ready(ex_ready), .flush(flush),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
        .out_imm_type(out_imm_type), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_illegal(out_illegal), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic er, input logic fl);
        in_valid = v;
        in_inst  = inst;
        in_pc    = pc;
        ex_ready = er;
        flush    = fl;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, LUI_X5, 32'h100, 1'b1, 1'b0);
        chk("rst_in_ready", in_ready, 0);
        tick;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_inst", out_inst, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_bubble_cnt", bubble_cnt, 0);

        // LUI x5
        rst = 1'b0;
        drive(1'b1, LUI_X5, 32'h100, 1'b1, 1'b0);
        chk("lui_imm_type", imm_type, 4);
        chk("lui_in_ready", in_ready, 1);
        tick;
        chk("lui_out_valid", out_valid, 1);
        chk("lui_out_rd", out_rd, 5);
        chk("lui_reg_write", out_reg_write, 1);
        chk("lui_out_pc", out_pc, 32'h100);
        chk("lui_out_imm_type", out_imm_type, 4);
        chk("lui_mem_read", out_mem_read, 0);

        // LW x6 then dependent ADD: one bubble
        drive(1'b1, LW_X6, 32'h104, 1'b1, 1'b0);
        chk("lw_imm_type", imm_type, 1);
        chk("lw_in_ready", in_ready, 1);
        tick;
        chk("lw_mem_read", out_mem_read, 1);
        chk("lw_out_rd", out_rd, 6);
        drive(1'b1, ADD_X7, 32'h108, 1'b1, 1'b0);
        chk("haz_in_ready", in_ready, 0);
        chk("add_imm_type", imm_type, 0);
        tick;
        chk("bubble_out_valid", out_valid, 0);
        chk("bubble_cnt_1", bubble_cnt, 1);
        chk("post_bubble_in_ready", in_ready, 1);
        tick;
        chk("add_out_valid", out_valid, 1);
        chk("add_out_inst", out_inst, ADD_X7);
        chk("add_out_rs1", out_rs1, 6);
        chk("add_out_rs2", out_rs2, 2);
        chk("add_out_rd", out_rd, 7);

        // LW x0 then ADD reading x0: no hazard
        drive(1'b1, LW_X0, 32'h10C, 1'b1, 1'b0);
        tick;
        chk("lwx0_reg_write", out_reg_write, 0);
        chk("lwx0_mem_read", out_mem_read, 1);
        drive(1'b1, ADD_X0, 32'h110, 1'b1, 1'b0);
        chk("x0_in_ready", in_ready, 1);
        tick;
        chk("x0_out_valid", out_valid, 1);
        chk("x0_out_inst", out_inst, ADD_X0);
        chk("x0_bubble_cnt", bubble_cnt, 1);

        // Back-pressure for 3 cycles with a store waiting
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, SW_X2, 32'h114, 1'b0, 1'b0);
            chk("stall_in_ready", in_ready, 0);
            tick;
            chk("stall_out_inst", out_inst, ADD_X0);
            chk("stall_out_valid", out_valid, 1);
        end
        drive(1'b1, SW_X2, 32'h114, 1'b1, 1'b0);
        chk("sw_imm_type", imm_type, 2);
        chk("sw_in_ready", in_ready, 1);
        tick;
        chk("sw_out_inst", out_inst, SW_X2);
        chk("sw_mem_write", out_mem_write, 1);
        chk("sw_reg_write", out_reg_write, 0);
        chk("sw_out_rd", out_rd, 4);

        // Flush coincident with hazard under back-pressure
        drive(1'b1, LW_X6, 32'h118, 1'b1, 1'b0);
        tick;
        drive(1'b1, ADD_X7, 32'h11C, 1'b0, 1'b1);
        chk("flush_in_ready", in_ready, 0);
        tick;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_bubble_cnt", bubble_cnt, 1);

        // Illegal opcode 0x7F with rd=31
        drive(1'b1, BAD_OP, 32'h120, 1'b1, 1'b0);
        chk("ill_imm_type", imm_type, 0);
        chk("ill_in_ready", in_ready, 1);
        tick;
        chk("ill_out_valid", out_valid, 1);
        chk("ill_illegal", out_illegal, 1);
        chk("ill_reg_write", out_reg_write, 0);

        // Load enable with no valid input drains
        drive(1'b0, LUI_X5, 32'h124, 1'b1, 1'b0);
        chk("idle_imm_type", imm_type, 4);
        tick;
        chk("idle_out_valid", out_valid, 0);

        // Counter saturation
        drive(1'b1, LW_X6, 32'h128, 1'b1, 1'b0);
        tick;
        force dut.r_bubble_cnt = 16'hFFFE;
        #1;
        release dut.r_bubble_cnt;
        #1;
        chk("preset_cnt", bubble_cnt, 16'hFFFE);
        drive(1'b1, ADD_X7, 32'h12C, 1'b1, 1'b0);
        tick;
        chk("sat_cnt_ffff", bubble_cnt, 16'hFFFF);
        tick;
        chk("sat_add_valid", out_valid, 1);
        drive(1'b1, LW_X6, 32'h130, 1'b1, 1'b0);
        tick;
        drive(1'b1, ADD_X7, 32'h134, 1'b1, 1'b0);
        chk("sat_haz_in_ready", in_ready, 0);
        tick;
        chk("sat_hold_ffff", bubble_cnt, 16'hFFFF);
        chk("sat_bubble_valid", out_valid, 0);

        // Reset mid-stall overrides, then empty pipeline
        drive(1'b1, LW_X6, 32'h138, 1'b1, 1'b0);
        tick;
        rst = 1'b1;
        drive(1'b1, ADD_X7, 32'h13C, 1'b0, 1'b1);
        chk("rst2_in_ready", in_ready, 0);
        tick;
        chk("rst2_bubble_cnt", bubble_cnt, 0);
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_mem_read", out_mem_read, 0);
        rst = 1'b0;
        drive(1'b1, ADD_X7, 32'h13C, 1'b0, 1'b0);
        chk("after_rst_in_ready", in_ready, 1);
        tick;
        chk("after_rst_out_valid", out_valid, 1);
        chk("after_rst_bubble_cnt", bubble_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_stage_ctrl.md
ID_STAGE_CTRL -- requirements
Module: id_stage_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  IF/ID holds a valid instruction.
REQ-004 in_inst  input  32  instruction word from IF/ID.
REQ-005 in_pc  input  32  PC of in_inst.
REQ-006 in_ready  output  1  instruction consumed this cycle (combinational).
REQ-007 imm_type  output  3  immediate type for the immediate extender, decoded combinationally from in_inst[6:0].
REQ-008 ex_ready  input  1  EX stage accepts the ID/EX contents this cycle.
REQ-009 flush  input  1  branch/jump redirect resolved in EX; kill ID and ID/EX.
REQ-010 out_valid, out_inst[31:0], out_pc[31:0], out_imm_type[2:0]  outputs  registered ID/EX payload.
REQ-011 out_rs1[4:0], out_rs2[4:0], out_rd[4:0]  outputs  registered register indices.
REQ-012 out_reg_write, out_mem_read, out_mem_write, out_illegal  outputs  1 each  registered control bits.
REQ-013 bubble_cnt  output  16  count of load-use bubbles inserted, saturating.

Function
REQ-014 imm_type codes SHALL be: NONE=0, I=1, S=2, B=3, U=4, J=5; values 6-7 never driven.
REQ-015 Decode: 0110011 R-> NONE, uses rs1+rs2, writes rd; 0010011/0000011/1100111 -> I, uses rs1, writes rd; 0100011 -> S, uses rs1+rs2; 1100011 -> B, uses rs1+rs2; 0110111/0010111 -> U, writes rd; 1101111 -> J, writes rd; 0001111 -> NONE, no reads/writes (NOP).
REQ-016 Any other opcode SHALL decode as NONE, no writes, illegal=1.
REQ-017 mem_read=1 only for 0000011; mem_write=1 only for 0100011; reg_write forced 0 when rd field is 0.
REQ-018 ID/EX register SHALL advance ("load enable") when out_valid=0 or ex_ready=1; otherwise all out_* hold.
REQ-019 hazard = in_valid & out_valid & out_mem_read & out_rd!=0 & ((rs1 used & rs1==out_rd) | (rs2 used & rs2==out_rd)), rs1=in_inst[19:15], rs2=in_inst[24:20].
REQ-020 in_ready = load enable & ~hazard & ~flush.
REQ-021 Priority each cycle: rst > flush > hazard > normal transfer.
REQ-022 flush=1: next cycle out_valid=0 regardless of ex_ready; in_ready=0; in_inst not captured.
REQ-023 hazard with load enable: next cycle out_valid=0 (bubble), other out_* don't-care, bubble_cnt += 1 unless 16'hFFFF.
REQ-024 hazard without load enable (ex_ready=0): hold everything; no bubble counted.
REQ-025 Normal transfer (load enable, in_valid, no hazard, no flush): capture in_inst, in_pc, decoded fields, out_valid=1 next cycle; latency 1 cycle.
REQ-026 Load enable with in_valid=0: out_valid<=0.
REQ-027 Unused-register indices SHALL still be captured verbatim from instruction fields.
REQ-028 Bubble resolves hazard in exactly one cycle: following cycle the same instruction transfers if ex_ready=1.
REQ-029 imm_type output SHALL track in_inst combinationally irrespective of in_valid, stall or flush.

Reset
REQ-030 rst=1: out_valid=0, all out_* payload/control=0, bubble_cnt=0, in_ready=0 during reset cycle.
REQ-031 rst asserted mid-stall or mid-flush SHALL override; first cycle after deassert behaves as empty pipeline.

Verification
REQ-032 LUI x5 (0x000052B7), in_valid=1, ex_ready=1 -> imm_type=4, next cycle out_valid=1, out_rd=5, out_reg_write=1.
REQ-033 LW x6,0(x1) then ADD x7,x6,x2 back-to-back, ex_ready=1 -> one cycle in_ready=0, one bubble (out_valid=0), bubble_cnt=1, ADD issues cycle after.
REQ-034 LW x0 then ADD x7,x0,x2 -> no bubble, bubble_cnt stays 0.
REQ-035 out_valid=1, ex_ready=0 for 3 cycles with new in_valid -> out_* stable, in_ready=0; ex_ready=1 -> transfer.
REQ-036 flush=1 coincident with hazard and ex_ready=0 -> next cycle out_valid=0, bubble_cnt unchanged; opcode 0x7F -> out_illegal=1, out_reg_write=0.
REQ-037 Force bubble_cnt to 16'hFFFF via repeated hazards -> further hazard leaves it at 16'hFFFF; rst -> 0.
